note_spawner: RTL

NOTE_SPAWNER -- requirements
Module: note_spawner

---
 rtl/note_spawner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/note_spawner.sv
// Paces square launches from the animation tick: waits a level-dependent
// number of frames, picks the lowest free slot and hands it a random lane and speed.
module note_spawner #(
  parameter int          N_SLOTS   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_ani_stb,
  input  logic                   i_run,
  input  logic [1:0]             i_level,
  input  logic [N_SLOTS-1:0]     i_slot_busy,
  output logic [N_SLOTS-1:0]     o_enable,
  output logic [4*N_SLOTS-1:0]   o_column,
  output logic [8*N_SLOTS-1:0]   o_speed,
  output logic [15:0]            o_spawn_count,
  output logic [15:0]            o_drop_count
);

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ALLOC, LAUNCH} state_t;

  state_t            state, state_next;
  logic [5:0]        interval;
  logic              pending;
  logic [15:0]       lfsr;
  logic [SLOT_W-1:0] launch_slot;
  logic [2:0]        launch_timer;

  logic              free_found;
  logic [SLOT_W-1:0] free_idx;
  logic              spawn_req;
  logic              req_drop;
  logic              enter_alloc;
  logic              alloc_ok;
  logic              alloc_fail;
  logic              launch_ack;
  logic              launch_abort;
  logic [3:0]        col_new;
  logic [7:0]        speed_new;
  logic [1:0]        drop_inc;

  function automatic logic [5:0] interval_last(input logic [1:0] lvl);
    case (lvl)
      2'd0:    interval_last = 6'd47;
      2'd1:    interval_last = 6'd31;
      2'd2:    interval_last = 6'd23;
      default: interval_last = 6'd15;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, cnt} + {15'd0, inc};
    sat_add = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Lowest-index free slot wins: scan downward so the last hit is the smallest k.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (!i_slot_busy[k]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(k);
      end
    end
  end

  assign spawn_req = (state != IDLE) && i_ani_stb && (interval >= interval_last(i_level));
  assign req_drop  = spawn_req && pending;
  assign col_new   = 4'b0001 << lfsr[1:0];
  assign speed_new = {6'd0, i_level} + 8'd1 + {7'd0, lfsr[2]};
  assign drop_inc  = {1'b0, req_drop} + {1'b0, alloc_fail | launch_abort};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    enter_alloc  = 1'b0;
    alloc_ok     = 1'b0;
    alloc_fail   = 1'b0;
    launch_ack   = 1'b0;
    launch_abort = 1'b0;
    case (state)
      IDLE: begin
        if (i_run) state_next = WAIT;
      end
      WAIT: begin
        if (!i_run) begin
          state_next = IDLE;
        end else if (pending) begin
          state_next  = ALLOC;
          enter_alloc = 1'b1;
        end
      end
      ALLOC: begin
        if (!i_run) begin
          state_next = IDLE;
        end else if (free_found) begin
          state_next = LAUNCH;
          alloc_ok   = 1'b1;
        end else begin
          state_next = WAIT;
          alloc_fail = 1'b1;
        end
      end
      LAUNCH: begin
        // A launch always runs to ack or timeout, even if the game stops meanwhile.
        if (i_slot_busy[launch_slot]) begin
          state_next = WAIT;
          launch_ack = 1'b1;
        end else if (launch_timer == 3'd7) begin
          state_next   = WAIT;
          launch_abort = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      interval      <= '0;
      pending       <= 1'b0;
      lfsr          <= LFSR_SEED;
      launch_slot   <= '0;
      launch_timer  <= '0;
      o_enable      <= '0;
      o_column      <= '0;
      o_speed       <= '0;
      o_spawn_count <= '0;
      o_drop_count  <= '0;
    end else begin
      if (state == IDLE)  interval <= '0;
      else if (i_ani_stb) interval <= spawn_req ? 6'd0 : interval + 6'd1;

      if (state == IDLE)              pending <= 1'b0;
      else if (spawn_req && !pending) pending <= 1'b1;
      else if (enter_alloc)           pending <= 1'b0;

      if (i_ani_stb && i_run) lfsr <= lfsr_step(lfsr);

      if (alloc_ok) begin
        launch_slot  <= free_idx;
        launch_timer <= '0;
        for (int k = 0; k < N_SLOTS; k++) begin
          o_enable[k] <= (free_idx == SLOT_W'(k));
          if (free_idx == SLOT_W'(k)) begin
            o_column[4*k +: 4] <= col_new;
            o_speed[8*k +: 8]  <= speed_new;
          end
        end
      end else if (launch_ack || launch_abort) begin
        o_enable <= '0;
      end else if (state == LAUNCH) begin
        launch_timer <= launch_timer + 3'd1;
      end

      o_spawn_count <= sat_add(o_spawn_count, {1'b0, launch_ack});
      o_drop_count  <= sat_add(o_drop_count, drop_inc);
    end
  end

endmodule
